// File: rtl/direction_smoother_if.sv
// Frame-in / decision-out bundle for direction_smoother.
// A frame is accepted on any clock edge where bins_valid_in && ready_out; a strobe with ready_out low is dropped and counted.
interface direction_smoother_if #(
    parameter int NUM_BINS  = 4,
    parameter int BIN_WIDTH = 24
);
    localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    logic [NUM_BINS*BIN_WIDTH-1:0] mag_bins_in;
    logic                          bins_valid_in;
    logic                          ready_out;
    logic [IDX_W-1:0]              direction_out;
    logic [BIN_WIDTH:0]            confidence_out;
    logic                          direction_valid_out;
    logic                          changed_out;
    logic [7:0]                    drop_count_out;
    logic [1:0]                    dbg_state;

    modport master (
        output mag_bins_in, bins_valid_in,
        input  ready_out, direction_out, confidence_out, direction_valid_out,
        input  changed_out, drop_count_out, dbg_state
    );

    modport slave (
        input  mag_bins_in, bins_valid_in,
        output ready_out, direction_out, confidence_out, direction_valid_out,
        output changed_out, drop_count_out, dbg_state
    );
endinterface

// File: rtl/direction_smoother.sv
// Per-bin EMA of localizer magnitudes followed by a hysteretic arg-max.
// Sequence per frame: IDLE -> UPDATE (one bin/cycle) -> SCAN (one bin/cycle) -> DECIDE -> IDLE.
module direction_smoother #(
    parameter int NUM_BINS    = 4,
    parameter int BIN_WIDTH   = 24,
    parameter int ALPHA_SHIFT = 2,
    parameter int HYST        = 1024
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    direction_smoother_if.slave bus
);
    localparam int BW    = BIN_WIDTH;
    localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic signed [BW-1:0]   MIN_VAL = {1'b1, {(BW-1){1'b0}}};
    localparam logic signed [BW+1:0]   HYST_V  = (BW+2)'(HYST);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_BINS-1);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SCAN, S_DECIDE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_idx;
    logic signed [BW-1:0]  r_frame [NUM_BINS];
    logic signed [BW-1:0]  r_avg   [NUM_BINS];
    logic                  r_primed;
    logic signed [BW-1:0]  r_best_val;
    logic signed [BW-1:0]  r_second_val;
    logic [IDX_W-1:0]      r_best_idx;
    logic [IDX_W-1:0]      r_direction;
    logic [BW:0]           r_confidence;
    logic                  r_dv;
    logic                  r_changed;
    logic [7:0]            r_drops;

    logic                  w_accept;
    logic                  w_last;
    logic signed [BW-1:0]  w_x;
    logic signed [BW-1:0]  w_avg_i;
    logic signed [BW:0]    w_diff;
    logic signed [BW-1:0]  w_step;
    logic signed [BW-1:0]  w_upd;
    logic signed [BW-1:0]  w_cur_val;
    logic signed [BW+1:0]  w_best_ext;
    logic signed [BW+1:0]  w_thresh;
    logic                  w_take;
    logic [IDX_W-1:0]      w_new_idx;
    logic signed [BW-1:0]  w_new_val;
    logic signed [BW-1:0]  w_other;
    logic signed [BW:0]    w_margin;
    logic [BW:0]           w_conf;
    logic                  w_changed;

    assign w_accept = bus.bins_valid_in && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_UPDATE;
            S_UPDATE: if (w_last)   w_next = S_SCAN;
            S_SCAN:   if (w_last)   w_next = S_DECIDE;
            S_DECIDE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The floored step keeps the new average between old average and sample, so BW bits suffice.
    assign w_x     = r_frame[r_idx];
    assign w_avg_i = r_avg[r_idx];
    assign w_diff  = {w_x[BW-1], w_x} - {w_avg_i[BW-1], w_avg_i};
    assign w_step  = BW'(w_diff >>> ALPHA_SHIFT);
    assign w_upd   = r_primed ? (w_avg_i + w_step) : w_x;

    assign w_cur_val  = r_avg[r_direction];
    assign w_best_ext = {{2{r_best_val[BW-1]}}, r_best_val};
    assign w_thresh   = {{2{w_cur_val[BW-1]}}, w_cur_val} + HYST_V;
    assign w_take     = !r_primed || (w_best_ext > w_thresh);
    assign w_new_idx  = w_take ? r_best_idx : r_direction;
    assign w_new_val  = w_take ? r_best_val : w_cur_val;

    // Holding a non-maximal winner leaves the true maximum as runner-up, which clamps the margin to 0.
    assign w_other    = (w_new_idx == r_best_idx) ? r_second_val : r_best_val;
    assign w_margin   = {w_new_val[BW-1], w_new_val} - {w_other[BW-1], w_other};
    assign w_conf     = w_margin[BW] ? '0 : w_margin;
    assign w_changed  = (w_new_idx != r_direction) || !r_primed;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx        <= '0;
            r_primed     <= 1'b0;
            r_best_val   <= '0;
            r_second_val <= '0;
            r_best_idx   <= '0;
            r_direction  <= '0;
            r_confidence <= '0;
            r_dv         <= 1'b0;
            r_changed    <= 1'b0;
            r_drops      <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                r_frame[i] <= '0;
                r_avg[i]   <= '0;
            end
        end else begin
            r_dv <= 1'b0;
            if (w_accept) begin
                for (int i = 0; i < NUM_BINS; i++)
                    r_frame[i] <= bus.mag_bins_in[i*BW +: BW];
            end
            if (r_state == S_UPDATE || r_state == S_SCAN)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (r_state == S_UPDATE)
                r_avg[r_idx] <= w_upd;
            if (r_state == S_SCAN) begin
                if (r_idx == '0) begin
                    r_best_val   <= w_avg_i;
                    r_best_idx   <= '0;
                    r_second_val <= MIN_VAL;
                end else if (w_avg_i > r_best_val) begin
                    r_second_val <= r_best_val;
                    r_best_val   <= w_avg_i;
                    r_best_idx   <= r_idx;
                end else if (w_avg_i > r_second_val) begin
                    r_second_val <= w_avg_i;
                end
            end
            if (r_state == S_DECIDE) begin
                r_direction  <= w_new_idx;
                r_confidence <= w_conf;
                r_changed    <= w_changed;
                r_dv         <= 1'b1;
                r_primed     <= 1'b1;
            end
            if (bus.bins_valid_in && r_state != S_IDLE && r_drops != 8'hFF)
                r_drops <= r_drops + 8'd1;
        end
    end

    assign bus.ready_out           = (r_state == S_IDLE);
    assign bus.direction_out       = r_direction;
    assign bus.confidence_out      = r_confidence;
    assign bus.direction_valid_out = r_dv;
    assign bus.changed_out         = r_changed;
    assign bus.drop_count_out      = r_drops;
    assign bus.dbg_state           = r_state;
endmodule

// File: tb/tb_direction_smoother.sv
// Directed and randomized frames for direction_smoother, checked against an arithmetic reference of the smoothing rules.
module tb_direction_smoother;
  localparam int NB = 4;
  localparam int BW = 24;
  localparam int AS = 2;
  localparam int HY = 1024;
  localparam int IW = 2;
  localparam int EW = IW + BW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  direction_smoother_if #(.NUM_BINS(NB), .BIN_WIDTH(BW)) bus ();

  direction_smoother #(
    .NUM_BINS(NB), .BIN_WIDTH(BW), .ALPHA_SHIFT(AS), .HYST(HY)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  longint m_avg[NB];
  bit     m_primed;
  int     m_cur;
  int     m_drops;
  longint cur_frame[NB];

  logic [63:0] last_dir, last_conf, last_chg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint d);
    longint p, q;
    p = longint'(1) << AS;
    q = d / p;
    if ((d % p) != 0 && d < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_avg[i] = 0;
    m_primed = 0;
    m_cur = 0;
    m_drops = 0;
    exp_q.delete();
  endtask

  task automatic model_frame();
    int best, nw;
    longint second, conf;
    bit chg;
    for (int i = 0; i < NB; i++)
      m_avg[i] = m_primed ? m_avg[i] + floor_div(cur_frame[i] - m_avg[i]) : cur_frame[i];
    best = 0;
    for (int i = 1; i < NB; i++) if (m_avg[i] > m_avg[best]) best = i;
    if (!m_primed || m_avg[best] > m_avg[m_cur] + HY) nw = best;
    else nw = m_cur;
    second = -(longint'(1) << 40);
    for (int j = 0; j < NB; j++) if (j != nw && m_avg[j] > second) second = m_avg[j];
    conf = m_avg[nw] - second;
    if (conf < 0) conf = 0;
    chg = (nw != m_cur) || !m_primed;
    m_cur = nw;
    m_primed = 1;
    exp_q.push_back({IW'(nw), (BW+1)'(conf), chg});
  endtask

  task automatic set_frame(input longint a, input longint b, input longint c, input longint d);
    cur_frame[0] = a; cur_frame[1] = b; cur_frame[2] = c; cur_frame[3] = d;
  endtask

  task automatic random_frame(input bit full);
    logic [BW-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r = BW'($urandom());
      cur_frame[i] = full ? longint'($signed(r)) : longint'($urandom_range(0, 12000)) - 2000;
    end
  endtask

  task automatic drive_bins();
    for (int i = 0; i < NB; i++) bus.mag_bins_in[i*BW +: BW] = cur_frame[i][BW-1:0];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dir"},   bus.direction_out, 0);
    check({tag, "_conf"},  bus.confidence_out, 0);
    check({tag, "_dv"},    bus.direction_valid_out, 0);
    check({tag, "_chg"},   bus.changed_out, 0);
    check({tag, "_drops"}, bus.drop_count_out, 0);
    check({tag, "_ready"}, bus.ready_out, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.bins_valid_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver: present one frame at a negedge, strobe again on edges lo..hi (dropped), await the result
  task automatic run_frame(input int lo, input int hi);
    int k;
    bit got;
    logic [EW-1:0] e;
    logic [BW-1:0] g;
    check("ready_before", bus.ready_out, 1);
    drive_bins();
    bus.bins_valid_in = 1'b1;
    model_frame();
    k = 0;
    got = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bus.direction_valid_out === 1'b1) begin
        got = 1;
        break;
      end
      bus.bins_valid_in = (k + 1 >= lo) && (k + 1 <= hi);
      if (bus.bins_valid_in) begin
        for (int i = 0; i < NB; i++) begin
          g = BW'($urandom());
          bus.mag_bins_in[i*BW +: BW] = g;
        end
      end
      k++;
    end
    bus.bins_valid_in = 1'b0;
    check("latency", got ? k : 999, 9);
    e = exp_q.pop_front();
    last_dir  = bus.direction_out;
    last_conf = bus.confidence_out;
    last_chg  = bus.changed_out;
    if (got) begin
      check("direction",  last_dir,  e[EW-1 -: IW]);
      check("confidence", last_conf, e[BW+1:1]);
      check("changed",    last_chg,  e[0]);
    end
    if (hi >= lo) m_drops = m_drops + (hi - lo + 1);
    if (m_drops > 255) m_drops = 255;
    check("drop_count", bus.drop_count_out, m_drops);
  endtask

  task automatic hold_check();
    logic [63:0] d0, c0;
    d0 = last_dir;
    c0 = last_conf;
    @(negedge clk);
    check("pulse_one_cycle", bus.direction_valid_out, 0);
    check("hold_dir",  bus.direction_out, d0);
    check("hold_conf", bus.confidence_out, c0);
  endtask

  initial begin
    bus.bins_valid_in = 1'b0;
    bus.mag_bins_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // priming frame
    set_frame(100, 5000, 200, -300);
    run_frame(1, 0);
    check("prime_dir", last_dir, 1);
    check("prime_conf", last_conf, 4800);
    check("prime_chg", last_chg, 1);
    hold_check();

    // hysteresis: three holds then a switch
    for (int n = 0; n < 4; n++) begin
      set_frame(100, 5000, 10000, -300);
      run_frame(1, 0);
      check("hyst_dir", last_dir, (n == 3) ? 2 : 1);
      check("hyst_chg", last_chg, (n == 3) ? 1 : 0);
    end
    check("hyst_conf", last_conf, 1898);
    hold_check();

    // ties on negative values go to the lowest index
    reset_dut();
    set_frame(-4000, -4000, -4000, -4000);
    run_frame(1, 0);
    check("tie_dir", last_dir, 0);
    check("tie_conf", last_conf, 0);
    check("tie_chg", last_chg, 1);

    // a single dropped strobe leaves the result untouched
    reset_dut();
    set_frame(100, 5000, 200, -300);
    run_frame(1, 0);
    set_frame(100, 5000, 10000, -300);
    run_frame(3, 3);
    check("bp_drops", bus.drop_count_out, 1);
    check("bp_dir", last_dir, 1);
    check("bp_conf", last_conf, 2350);
    check("bp_chg", last_chg, 0);

    // drop counter saturation
    for (int n = 0; n < 34; n++) begin
      random_frame(1'b0);
      run_frame(1, 9);
    end
    check("drops_saturated", bus.drop_count_out, 255);

    // asynchronous reset in the middle of SCAN
    reset_dut();
    set_frame(100, 5000, 200, -300);
    run_frame(1, 0);
    set_frame(9000, 1, 2, 3);
    drive_bins();
    bus.bins_valid_in = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.bins_valid_in = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_frame(0, 0, 0, 7000);
    run_frame(1, 0);
    check("reprime_dir", last_dir, 3);
    check("reprime_conf", last_conf, 7000);
    check("reprime_chg", last_chg, 1);

    // randomized frames, mixed ranges, occasional drop windows
    for (int n = 0; n < 40; n++) begin
      int lo, hi;
      random_frame($urandom_range(0, 3) == 0);
      lo = 1; hi = 0;
      if ($urandom_range(0, 2) == 0) begin
        lo = $urandom_range(1, 9);
        hi = $urandom_range(lo, 9);
      end
      run_frame(lo, hi);
    end

    // back-to-back frames every 10 cycles
    reset_dut();
    for (int n = 0; n < 10; n++) begin
      random_frame(n[0]);
      run_frame(1, 0);
    end
    check("throughput_drops", bus.drop_count_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/direction_smoother.md
Name: direction_smoother

Overview:
Consumes the per-quadrant magnitude bins produced by the localizer each FFT frame. Applies a per-bin exponential moving average, then picks the winning direction with hysteresis so the output does not chatter between quadrants. Produces a stable direction index, a confidence margin and a change flag for the downstream actuator/display logic.

Parameters:
NUM_BINS, 4, number of direction bins per frame
BIN_WIDTH, 24, signed width of each input bin and each averaged bin
ALPHA_SHIFT, 2, EMA weight = 2^-ALPHA_SHIFT
HYST, 1024, margin a challenger's average must strictly exceed the current winner's average by to take over

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
mag_bins_in  input  NUM_BINS*BIN_WIDTH  packed signed bins; bin i at [i*BIN_WIDTH +: BIN_WIDTH]
bins_valid_in  input  1  one-cycle frame strobe
ready_out  output  1  high only in IDLE; frame accepted when bins_valid_in && ready_out
direction_out  output  $clog2(NUM_BINS)  current winning bin index
confidence_out  output  BIN_WIDTH+1  unsigned; winner average minus second-highest average
direction_valid_out  output  1  one-cycle pulse when outputs update
changed_out  output  1  valid with direction_valid_out; direction_out differs from previous value, or first decision after reset
drop_count_out  output  8  saturating count of strobes arriving while ready_out low

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all averages 0, primed=0, direction_out=0, confidence_out=0, direction_valid_out=0, changed_out=0, drop_count_out=0. ready_out=1, since it is decoded from IDLE.
- On acceptance, latch mag_bins_in into a frame register and go to UPDATE.
- UPDATE, NUM_BINS cycles, one bin per cycle, index 0 upward:
  - If primed=0: avg[i] <= x[i].
  - Else: avg[i] <= avg[i] + ((x[i] - avg[i]) >>> ALPHA_SHIFT).
  - Difference is computed at BIN_WIDTH+1 bits with an arithmetic shift (floor). The result always lies between avg and x, so it never overflows BIN_WIDTH.
- SCAN, NUM_BINS cycles:
  - Sequential search for the highest average and the second-highest average.
  - Strict greater-than compare, so ties go to the lowest index.
- DECIDE, 1 cycle. Let best be the scan winner and cur = direction_out.
  - If primed=0: new = best.
  - Else: new = best only if avg[best] > avg[cur] + HYST, evaluated at BIN_WIDTH+2 bits. Otherwise new = cur.
  - direction_out <= new.
  - confidence_out <= avg[new] - second, where second is the highest average among bins other than new, clamped at 0.
  - changed_out <= (new != cur) || !primed.
  - direction_valid_out pulses; primed <= 1; FSM returns to IDLE.
- Latency: the acceptance edge is cycle 0; direction_valid_out is high in cycle 2*NUM_BINS+1 (cycle 9 with defaults). Throughput is one frame per 2*NUM_BINS+2 cycles.
- Strobe while ready_out=0: the frame is ignored, averages are unaffected, and drop_count_out increments, saturating at 255.
- direction_out and confidence_out hold between pulses.
- Reset asserted mid-frame: immediate return to reset state. The partial frame is discarded and the next accepted frame re-primes.

Test Plan:
- Prime: after reset, frame {100, 5000, 200, -300} -> pulse 9 cycles after acceptance; direction=1, confidence=4800, changed=1.
- Hysteresis hold then switch: prime as above, then repeat frame {100, 5000, 10000, -300}.
  - avg2 goes 2650, 4487, 5865; the threshold is 6024, so direction stays 1 and changed=0 on these frames.
  - 4th repeat: avg2=6898 -> direction=2, changed=1, confidence=1898.
- Tie/negative: after reset, frame {-4000, -4000, -4000, -4000} -> direction=0, confidence=0, changed=1.
- Backpressure: strobe bins_valid_in at cycle 3 after an acceptance -> ignored, drop_count=1, averages and result identical to the no-strobe case.
  - 300 such drops -> drop_count=255.
- Async reset mid-SCAN: all outputs 0 the same cycle, ready_out=1.
  - Next frame {0, 0, 0, 7000} is treated as priming -> direction=3, confidence=7000, changed=1.
- Throughput: back-to-back strobes every 10 cycles -> every frame accepted, drop_count stays 0.
